// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD loader and its min tracker.
package sad_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 6;
  localparam int N_WORDS = 64;
  localparam int SAD_W   = 32;
  localparam int IDX_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    SETTLE = 3'd3,
    GO     = 3'd4,
    WAIT   = 3'd5,
    RESULT = 3'd6
  } state_t;
endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum SAD and the job index that produced it; cleared on a fresh A load.
module sad_min_tracker
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic [SAD_W-1:0] sad,
  output logic [SAD_W-1:0] min_sad,
  output logic [IDX_W-1:0] min_idx,
  output logic [IDX_W-1:0] job_idx
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_sad <= '1;
      min_idx <= '0;
      job_idx <= '0;
    end else if (clear) begin
      min_sad <= '1;
      min_idx <= '0;
      job_idx <= '0;
    end else if (capture) begin
      // strict compare: ties keep the earlier index
      if (sad < min_sad) begin
        min_sad <= sad;
        min_idx <= job_idx;
      end
      job_idx <= job_idx + 1'b1;
    end
  end
endmodule

// File: rtl/sad_loader.sv
// Streams current (A) and candidate (B) blocks into the SAD SRAMs, kicks the core, returns the SAD.
// Optional min/index tracking outputs are built when SAD_LOADER_MIN_TRACK_EN is defined.
module sad_loader #(
  parameter int DATA_W  = sad_pkg::DATA_W,
  parameter int ADDR_W  = sad_pkg::ADDR_W,
  parameter int N_WORDS = sad_pkg::N_WORDS
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [DATA_W-1:0]         In_Data,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic                      Keep_A,
  output logic [DATA_W-1:0]         MA_di31,
  output logic [ADDR_W-1:0]         MA_Addr6,
  output logic                      MA_enb,
  output logic                      MA_web,
  output logic [DATA_W-1:0]         MB_di31,
  output logic [ADDR_W-1:0]         MB_Addr6,
  output logic                      MB_enb,
  output logic                      MB_web,
  output logic                      Go_t,
  input  logic                      Done_t,
  input  logic [sad_pkg::SAD_W-1:0] SAD_Out_t,
  output logic [sad_pkg::SAD_W-1:0] Res_Data,
  output logic                      Res_Valid,
  input  logic                      Res_Ready,
  output logic                      Busy
`ifdef SAD_LOADER_MIN_TRACK_EN
  ,
  output logic [sad_pkg::SAD_W-1:0] Min_SAD,
  output logic [sad_pkg::IDX_W-1:0] Min_Idx,
  output logic [sad_pkg::IDX_W-1:0] Job_Idx
`endif
);
  import sad_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              a_loaded, done_q;
  logic              accept, fresh_a, to_a, last_word, capture;

  assign In_Ready  = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
  assign Busy      = (state != IDLE);
  assign accept    = In_Valid && In_Ready;
  // Keep_A only counts once A actually holds a complete block
  assign fresh_a   = !(Keep_A && a_loaded);
  assign to_a      = (state == LOAD_A) || ((state == IDLE) && fresh_a);
  assign last_word = (cnt == ADDR_W'(N_WORDS - 1));
  assign capture   = (state == WAIT) && Done_t && !done_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fresh_a ? LOAD_A : LOAD_B;
      LOAD_A:  if (accept && last_word) state_nx = LOAD_B;
      LOAD_B:  if (accept && last_word) state_nx = SETTLE;
      SETTLE:  state_nx = GO;
      GO:      state_nx = WAIT;
      WAIT:    if (capture) state_nx = RESULT;
      RESULT:  if (Res_Ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= '0;
      a_loaded  <= 1'b0;
      done_q    <= 1'b0;
      Go_t      <= 1'b0;
      MA_di31   <= '0;
      MA_Addr6  <= '0;
      MA_enb    <= 1'b0;
      MA_web    <= 1'b0;
      MB_di31   <= '0;
      MB_Addr6  <= '0;
      MB_enb    <= 1'b0;
      MB_web    <= 1'b0;
      Res_Data  <= '0;
      Res_Valid <= 1'b0;
    end else begin
      done_q <= Done_t;
      // registered, so the pulse lands the cycle after GO (last B accept + 3)
      Go_t   <= (state == GO);
      MA_enb <= accept && to_a;
      MA_web <= accept && to_a;
      MB_enb <= accept && !to_a;
      MB_web <= accept && !to_a;
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (to_a) begin
          MA_di31  <= In_Data;
          MA_Addr6 <= cnt;
        end else begin
          MB_di31  <= In_Data;
          MB_Addr6 <= cnt;
        end
        if ((state == IDLE) && fresh_a)    a_loaded <= 1'b0;
        if ((state == LOAD_A) && last_word) a_loaded <= 1'b1;
      end
      if (capture) begin
        Res_Data  <= SAD_Out_t;
        Res_Valid <= 1'b1;
      end else if ((state == RESULT) && Res_Ready) begin
        Res_Valid <= 1'b0;
      end
    end
  end

`ifdef SAD_LOADER_MIN_TRACK_EN
  sad_min_tracker u_min (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (accept && (state == IDLE) && fresh_a),
    .capture (capture),
    .sad     (SAD_Out_t),
    .min_sad (Min_SAD),
    .min_idx (Min_Idx),
    .job_idx (Job_Idx)
  );
`endif
endmodule

// File: tb/tb_sad_loader.sv
// Directed self-checking bench for sad_loader (min tracking checked when SAD_LOADER_MIN_TRACK_EN is set).
module tb_sad_loader;
  logic        Clk = 0, Rst = 1;
  logic [31:0] In_Data = '0;
  logic        In_Valid = 0, Keep_A = 0;
  logic        In_Ready;
  logic [31:0] MA_di31, MB_di31;
  logic [5:0]  MA_Addr6, MB_Addr6;
  logic        MA_enb, MA_web, MB_enb, MB_web, Go_t;
  logic        Done_t = 0;
  logic [31:0] SAD_Out_t = '0;
  logic [31:0] Res_Data;
  logic        Res_Valid, Busy;
  logic        Res_Ready = 0;
`ifdef SAD_LOADER_MIN_TRACK_EN
  logic [31:0] Min_SAD;
  logic [15:0] Min_Idx, Job_Idx;
`endif

  int errors = 0, checks = 0;
  int cyc = 0;

  // write/go log owned by the monitor; tests index from a snapshot of the sizes
  logic [5:0]  ma_a[$], mb_a[$];
  logic [31:0] ma_d[$], mb_d[$];
  int          go_cyc[$];
  int          viol = 0;
  bit          prev_acc = 0;

  sad_loader dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Keep_A(Keep_A), .MA_di31(MA_di31), .MA_Addr6(MA_Addr6), .MA_enb(MA_enb), .MA_web(MA_web),
    .MB_di31(MB_di31), .MB_Addr6(MB_Addr6), .MB_enb(MB_enb), .MB_web(MB_web),
    .Go_t(Go_t), .Done_t(Done_t), .SAD_Out_t(SAD_Out_t), .Res_Data(Res_Data),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Busy(Busy)
`ifdef SAD_LOADER_MIN_TRACK_EN
    , .Min_SAD(Min_SAD), .Min_Idx(Min_Idx), .Job_Idx(Job_Idx)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Rst) prev_acc = 0;
    else begin
      if (((MA_enb || MB_enb) != prev_acc) || (MA_enb && MB_enb) ||
          (MA_web != MA_enb) || (MB_web != MB_enb)) viol++;
      if (MA_enb) begin ma_a.push_back(MA_Addr6); ma_d.push_back(MA_di31); end
      if (MB_enb) begin mb_a.push_back(MB_Addr6); mb_d.push_back(MB_di31); end
      if (Go_t) go_cyc.push_back(cyc);
      prev_acc = In_Valid && In_Ready;
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1; In_Valid = 0; Done_t = 0; Res_Ready = 0;
    tick(); tick();
    Rst = 0;
    tick();
  endtask

  // entries from start must be addr 0..63 with data base+i
  function automatic int bad_seq(input bit mem_a, input int start, input int base);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem_a) begin
        if (ma_a[start+i] !== 6'(i) || ma_d[start+i] !== 32'(base + i)) bad++;
      end else begin
        if (mb_a[start+i] !== 6'(i) || mb_d[start+i] !== 32'(base + i)) bad++;
      end
    end
    return bad;
  endfunction

  task automatic send_words(input int n, input int base, input bit keep, input bit bubbles,
                            output int last_acc, output int cycles);
    int sent = 0;
    cycles = 0; last_acc = -1;
    Keep_A = keep;
    while (sent < n && cycles < 4000) begin
      In_Valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      In_Data  = 32'(base + sent);
      if (In_Valid && In_Ready) begin sent++; last_acc = cyc; end
      cycles++;
      tick();
    end
    In_Valid = 0;
    checks++;
    if (sent != n) begin errors++; $display("FAIL send_words: accepted %0d want %0d", sent, n); end
  endtask

  // raise Done, watch the result through a hold of Res_Ready low, then handshake
  task automatic finish_job(input logic [31:0] sad, input int hold, input bit drop_done,
                            output logic [31:0] got, output bit valid_ok, output bit stable_ok);
    Done_t = 1; SAD_Out_t = sad;
    tick();
    valid_ok  = (Res_Valid === 1'b1);
    got       = Res_Data;
    stable_ok = 1;
    SAD_Out_t = 32'hDEAD_BEEF;
    for (int i = 0; i < hold; i++) begin
      In_Valid = 1;
      tick();
      if (Res_Valid !== 1'b1 || Res_Data !== got || In_Ready !== 1'b0) stable_ok = 0;
    end
    In_Valid = 0;
    Res_Ready = 1;
    tick();
    Res_Ready = 0;
    if (Res_Valid !== 1'b0 || Busy !== 1'b0) valid_ok = 0;
    if (drop_done) Done_t = 0;
  endtask

  task automatic test_reset();
    Rst = 1; #1;
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", In_Ready); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if ({MA_enb, MA_web, MB_enb, MB_web, Go_t, Res_Valid} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {MA_enb, MA_web, MB_enb, MB_web, Go_t, Res_Valid}); end
    checks++; if (Res_Data !== 32'd0 || MA_di31 !== 32'd0 || MB_Addr6 !== 6'd0)
      begin errors++; $display("FAIL reset_data: got %h/%h/%h want 0", Res_Data, MA_di31, MB_Addr6); end
    do_reset();
    checks++; if (In_Ready !== 1'b1 || Busy !== 1'b0)
      begin errors++; $display("FAIL post_reset: ready=%b busy=%b want 1/0", In_Ready, Busy); end
  endtask

  task automatic test_full_load();
    int a0 = ma_a.size(), b0 = mb_a.size(), g0 = go_cyc.size(), v0 = viol;
    int last, ncyc;
    logic [31:0] got; bit vok, sok;
    send_words(128, 0, 0, 0, last, ncyc);
    tick(); tick(); tick(); tick();
    checks++; if (ncyc !== 128) begin errors++; $display("FAIL full_no_stall: cycles %0d want 128", ncyc); end
    checks++; if (ma_a.size() - a0 !== 64) begin errors++; $display("FAIL full_ma_count: got %0d want 64", ma_a.size() - a0); end
    else begin checks++; if (bad_seq(1, a0, 0) != 0) begin errors++; $display("FAIL full_ma_seq: %0d bad want 0", bad_seq(1, a0, 0)); end end
    checks++; if (mb_a.size() - b0 !== 64) begin errors++; $display("FAIL full_mb_count: got %0d want 64", mb_a.size() - b0); end
    else begin checks++; if (bad_seq(0, b0, 64) != 0) begin errors++; $display("FAIL full_mb_seq: %0d bad want 0", bad_seq(0, b0, 64)); end end
    checks++; if (go_cyc.size() - g0 !== 1) begin errors++; $display("FAIL full_go_count: got %0d want 1", go_cyc.size() - g0); end
    else begin checks++; if (go_cyc[g0] - last !== 3) begin errors++; $display("FAIL full_go_latency: got %0d want 3", go_cyc[g0] - last); end end
    checks++; if (viol !== v0) begin errors++; $display("FAIL full_write_timing: %0d bad cycles want 0", viol - v0); end
    checks++; if (Res_Valid !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL full_wait: valid=%b busy=%b want 0/1", Res_Valid, Busy); end
    finish_job(32'd1234, 0, 1, got, vok, sok);
    checks++; if (!vok) begin errors++; $display("FAIL full_res_valid: got 0 want 1 one cycle after done edge"); end
    checks++; if (got !== 32'd1234) begin errors++; $display("FAIL full_res_data: got %0d want 1234", got); end
  endtask

  task automatic test_keep_a();
    int a0 = ma_a.size(), b0 = mb_a.size(), g0 = go_cyc.size();
    int last, ncyc;
    logic [31:0] got; bit vok, sok;
    send_words(64, 200, 1, 0, last, ncyc);
    tick(); tick(); tick(); tick();
    checks++; if (ma_a.size() !== a0) begin errors++; $display("FAIL keep_ma_untouched: %0d writes want 0", ma_a.size() - a0); end
    checks++; if (mb_a.size() - b0 !== 64) begin errors++; $display("FAIL keep_mb_count: got %0d want 64", mb_a.size() - b0); end
    else begin checks++; if (bad_seq(0, b0, 200) != 0) begin errors++; $display("FAIL keep_mb_seq: %0d bad want 0", bad_seq(0, b0, 200)); end end
    checks++; if (go_cyc.size() - g0 !== 1) begin errors++; $display("FAIL keep_go_count: got %0d want 1", go_cyc.size() - g0); end
    // Done left high on purpose for the stale-done scenario
    finish_job(32'd9, 0, 0, got, vok, sok);
    checks++; if (!vok || got !== 32'd9) begin errors++; $display("FAIL keep_result: valid_ok=%b data=%0d want 1/9", vok, got); end
  endtask

  task automatic test_stale_done();
    int last, ncyc;
    logic [31:0] got; bit vok, sok;
    send_words(64, 300, 1, 0, last, ncyc);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (Res_Valid !== 1'b0 || Busy !== 1'b1)
      begin errors++; $display("FAIL stale_no_capture: valid=%b busy=%b want 0/1", Res_Valid, Busy); end
    Done_t = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL stale_low: valid=%b want 0", Res_Valid); end
    finish_job(32'd77, 0, 1, got, vok, sok);
    checks++; if (!vok || got !== 32'd77) begin errors++; $display("FAIL stale_capture: valid_ok=%b data=%0d want 1/77", vok, got); end
  endtask

  task automatic test_backpressure();
    int a0 = ma_a.size(), b0 = mb_a.size(), v0 = viol;
    int last, ncyc;
    logic [31:0] got; bit vok, sok;
    send_words(128, 1000, 0, 1, last, ncyc);
    tick(); tick(); tick(); tick();
    checks++; if (viol !== v0) begin errors++; $display("FAIL bp_write_timing: %0d bad cycles want 0", viol - v0); end
    checks++; if (ma_a.size() - a0 !== 64 || mb_a.size() - b0 !== 64)
      begin errors++; $display("FAIL bp_counts: a=%0d b=%0d want 64/64", ma_a.size() - a0, mb_a.size() - b0); end
    else begin
      checks++; if (bad_seq(1, a0, 1000) + bad_seq(0, b0, 1064) != 0)
        begin errors++; $display("FAIL bp_contiguous: %0d bad want 0", bad_seq(1, a0, 1000) + bad_seq(0, b0, 1064)); end
    end
    finish_job(32'h0001_5A5A, 10, 1, got, vok, sok);
    checks++; if (!vok || got !== 32'h0001_5A5A) begin errors++; $display("FAIL bp_result: valid_ok=%b data=%h want 1/00015a5a", vok, got); end
    checks++; if (!sok) begin errors++; $display("FAIL bp_hold_stable: stable=%b want 1", sok); end
  endtask

  task automatic test_reset_mid();
    int a0, b0, last, ncyc;
    logic [31:0] got; bit vok, sok;
    send_words(30, 0, 0, 0, last, ncyc);
    Rst = 1; #1;
    checks++; if (In_Ready !== 1'b1 || Busy !== 1'b0 || MA_enb !== 1'b0 || MA_web !== 1'b0 || Go_t !== 1'b0)
      begin errors++; $display("FAIL mid_reset_async: ready=%b busy=%b enb=%b web=%b go=%b want 1/0/0/0/0",
                               In_Ready, Busy, MA_enb, MA_web, Go_t); end
    tick(); Rst = 0; tick();
    a0 = ma_a.size(); b0 = mb_a.size();
    send_words(128, 500, 1, 0, last, ncyc);
    tick(); tick();
    checks++; if (ma_a.size() - a0 !== 64 || mb_a.size() - b0 !== 64)
      begin errors++; $display("FAIL mid_reload_counts: a=%0d b=%0d want 64/64", ma_a.size() - a0, mb_a.size() - b0); end
    else begin
      checks++; if (bad_seq(1, a0, 500) + bad_seq(0, b0, 564) != 0)
        begin errors++; $display("FAIL mid_reload_seq: %0d bad want 0", bad_seq(1, a0, 500) + bad_seq(0, b0, 564)); end
    end
    finish_job(32'd3, 0, 1, got, vok, sok);
    checks++; if (!vok || got !== 32'd3) begin errors++; $display("FAIL mid_result: valid_ok=%b data=%0d want 1/3", vok, got); end
  endtask

`ifdef SAD_LOADER_MIN_TRACK_EN
  task automatic test_min_track();
    int last, ncyc;
    logic [31:0] got; bit vok, sok;
    do_reset();
    checks++; if (Min_SAD !== 32'hFFFF_FFFF || Min_Idx !== 16'd0 || Job_Idx !== 16'd0)
      begin errors++; $display("FAIL min_reset: %h/%0d/%0d want ffffffff/0/0", Min_SAD, Min_Idx, Job_Idx); end
    send_words(128, 0, 0, 0, last, ncyc); tick(); tick(); tick(); tick();
    finish_job(32'd500, 0, 1, got, vok, sok);
    send_words(64, 0, 1, 0, last, ncyc); tick(); tick(); tick(); tick();
    finish_job(32'd200, 0, 1, got, vok, sok);
    send_words(64, 0, 1, 0, last, ncyc); tick(); tick(); tick(); tick();
    finish_job(32'd200, 0, 1, got, vok, sok);
    checks++; if (Min_SAD !== 32'd200) begin errors++; $display("FAIL min_sad: got %0d want 200", Min_SAD); end
    checks++; if (Min_Idx !== 16'd1) begin errors++; $display("FAIL min_idx: got %0d want 1", Min_Idx); end
    checks++; if (Job_Idx !== 16'd3) begin errors++; $display("FAIL job_idx: got %0d want 3", Job_Idx); end
    // a fresh A load clears the tracker at its first accept
    Keep_A = 0; In_Valid = 1; tick(); In_Valid = 0;
    checks++; if (Min_SAD !== 32'hFFFF_FFFF || Job_Idx !== 16'd0)
      begin errors++; $display("FAIL min_clear: %h/%0d want ffffffff/0", Min_SAD, Job_Idx); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_keep_a();
    test_stale_done();
    test_backpressure();
    test_reset_mid();
`ifdef SAD_LOADER_MIN_TRACK_EN
    test_min_track();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
